ado_event_controller: RTL and testbench
=======================================

Name: ado_event_controller

Overview:
- Sequences detection on the output stream of an amplitude-difference operator.
- After a start command it discards pipeline warm-up samples, then calibrates an adaptive threshold from the mean operator output over a fixed window.
- It then arms event detection, emitting a spike pulse per threshold crossing with a refractory hold-off.
- Sits directly downstream of the operator and upstream of event logging/counting logic.

Parameters:
- OUT_BITS, 16, width of operator output and threshold.
- WARMUP_SAMPLES, 8, valid samples discarded after start (operator delay line plus pipeline fill); legal range 1..255.
- CAL_LOG2, 8, calibration window = 2**CAL_LOG2 valid samples; legal range 1..16.
- GAIN_SH, 2, threshold = mean << GAIN_SH.
- REFRACT_SAMPLES, 32, valid samples ignored after each spike; legal range 1..65535.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- op_valid, input, 1, op_data carries a new sample this cycle.
- op_data, input, OUT_BITS, unsigned operator output.
- start, input, 1, single-cycle command to begin warm-up and calibration.
- abort, input, 1, single-cycle command to return to IDLE.
- spike, output, 1, one-cycle pulse on detected event.
- spike_count, output, 16, saturating event counter.
- threshold, output, OUT_BITS, current detection threshold.
- cal_done, output, 1, one-cycle pulse when calibration completes.
- state, output, 3, FSM state encoding.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE; spike=0; cal_done=0; spike_count=0; threshold=all ones (no false spikes before calibration); all internal counters and the accumulator=0.
- State encoding: IDLE=0, WARMUP=1, CALIB=2, ARMED=3, REFRACT=4; values 5-7 are illegal and recover to IDLE on the next clock.
- IDLE: start=1 -> WARMUP; warm-up counter cleared. op_valid is ignored.
- WARMUP: each op_valid increments the counter. On the WARMUP_SAMPLES-th valid sample -> CALIB, with accumulator and sample counter cleared.
- CALIB:
  - Each op_valid adds op_data to the accumulator (width OUT_BITS+CAL_LOG2, no overflow possible).
  - On the 2**CAL_LOG2-th valid sample, including that sample: mean = acc >> CAL_LOG2; thr = mean << GAIN_SH.
  - thr saturates to all ones if any bit is lost; thr forced to 1 if 0.
  - threshold is updated, cal_done pulses the next cycle, state -> ARMED.
- ARMED: on op_valid with op_data >= threshold:
  - spike=1 on the following cycle (registered, latency 1).
  - spike_count increments, saturating at 0xFFFF.
  - Refractory counter loaded with REFRACT_SAMPLES; state -> REFRACT.
- REFRACT: each op_valid decrements the counter; the sample is never compared. When a valid sample decrements the counter to 0 -> ARMED, and the next valid sample is eligible.
- spike and cal_done deassert the cycle after assertion; each is never high for more than 1 cycle.
- abort=1 in any state -> IDLE on the next edge; counters and accumulator cleared; threshold and spike_count retained; in-flight spike/cal_done pulses still complete.
- start and abort in the same cycle: abort wins.
- start outside IDLE: ignored.
- op_valid=0 cycles: no counter, accumulator, or state change except abort.
- Re-start from IDLE after a prior run: full re-calibration. spike_count is not cleared; it clears only on rst.
- Asynchronous reset mid-run: immediately returns all registers to reset values.

Optional Feature:
- Macro: ADO_MANUAL_THR_EN.
- Defined:
  - Adds input thr_wr (1 bit) and input thr_wdata (OUT_BITS).
  - thr_wr=1 in IDLE, ARMED, or REFRACT loads threshold=thr_wdata (0 coerced to 1) the next cycle.
  - In IDLE it also moves to ARMED, skipping warm-up and calibration.
  - Ignored in WARMUP and CALIB.
  - abort outranks thr_wr; thr_wr outranks start in IDLE.
- Undefined: ports absent; threshold changes only through calibration and reset.

Test Plan:
- Bench parameters: WARMUP_SAMPLES=2, CAL_LOG2=2, GAIN_SH=1, REFRACT_SAMPLES=3, OUT_BITS=16.
- Reset check: rst pulse -> state=0, threshold=0xFFFF, spike_count=0, spike=0; op_valid with data 0xFFFE gives no spike.
- Calibration: start, then valid data 9,9 (discarded), then 10,20,30,40 -> mean=25, threshold=50, cal_done pulses once, state=3.
- Detection/refractory: armed, thr=50; valid data 49,50,60,70,80,55:
  - spike one cycle after 50; 60/70/80 ignored; spike on 55.
  - spike_count=2.
- Saturation: calibrate with four samples of 0xC000 -> threshold=0xFFFF; calibrate with all zeros -> threshold=1.
- Abort: abort asserted during CALIB after 2 samples, same cycle as start -> IDLE; threshold unchanged.
  - New start recalibrates from zero: accumulator excludes old samples.
- ADO_MANUAL_THR_EN: thr_wr with thr_wdata=100 in IDLE -> state=3, threshold=100; valid 100 -> spike.
  - thr_wr during CALIB -> ignored.

Source files
------------

// File: rtl/ado_event_controller_if.sv
// Operator-side sample stream and event/status outputs of ado_event_controller.
// ADO_MANUAL_THR_EN adds the thr_wr/thr_wdata manual threshold write signals.
interface ado_event_controller_if #(
    parameter int OUT_BITS = 16
);
    // op_valid qualifies op_data for exactly one cycle; there is no ready, every valid sample is consumed.
    logic                op_valid;
    logic [OUT_BITS-1:0] op_data;
    logic                start;
    logic                abort;
`ifdef ADO_MANUAL_THR_EN
    logic                thr_wr;
    logic [OUT_BITS-1:0] thr_wdata;
`endif
    logic                spike;
    logic [15:0]         spike_count;
    logic [OUT_BITS-1:0] threshold;
    logic                cal_done;
    logic [2:0]          state;

`ifdef ADO_MANUAL_THR_EN
    modport master (
        output op_valid, op_data, start, abort, thr_wr, thr_wdata,
        input  spike, spike_count, threshold, cal_done, state
    );
    modport slave (
        input  op_valid, op_data, start, abort, thr_wr, thr_wdata,
        output spike, spike_count, threshold, cal_done, state
    );
`else
    modport master (
        output op_valid, op_data, start, abort,
        input  spike, spike_count, threshold, cal_done, state
    );
    modport slave (
        input  op_valid, op_data, start, abort,
        output spike, spike_count, threshold, cal_done, state
    );
`endif
endinterface

// File: rtl/ado_event_controller.sv
// Warm-up / calibration / armed-detection sequencer for an amplitude-difference operator stream.
// Optional ADO_MANUAL_THR_EN: manual threshold writes that can also arm directly from IDLE.
module ado_event_controller #(
    parameter int OUT_BITS        = 16,
    parameter int WARMUP_SAMPLES  = 8,
    parameter int CAL_LOG2        = 8,
    parameter int GAIN_SH         = 2,
    parameter int REFRACT_SAMPLES = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    ado_event_controller_if.slave       bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WARMUP  = 3'd1;
    localparam logic [2:0] S_CALIB   = 3'd2;
    localparam logic [2:0] S_ARMED   = 3'd3;
    localparam logic [2:0] S_REFRACT = 3'd4;

    localparam int ACC_W = OUT_BITS + CAL_LOG2;
    localparam int THR_W = OUT_BITS + GAIN_SH;

    logic [2:0]          state_q;
    logic [7:0]          warm_q;
    logic [CAL_LOG2-1:0] cal_cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic [15:0]         refract_q;
    logic [OUT_BITS-1:0] thr_q;
    logic [15:0]         spike_count_q;
    logic                spike_q;
    logic                cal_done_q;

    logic [ACC_W-1:0]    acc_next;
    logic [OUT_BITS-1:0] mean;
    logic [THR_W-1:0]    thr_wide;
    logic [OUT_BITS-1:0] cal_thr;
    logic                hit;

    // The closing sample of the window is folded in before the mean is taken.
    always_comb begin
        acc_next = acc_q + ACC_W'(bus.op_data);
        mean     = acc_next[ACC_W-1:CAL_LOG2];
        thr_wide = THR_W'(mean) << GAIN_SH;
        if (|(thr_wide >> OUT_BITS))
            cal_thr = '1;
        else if (thr_wide[OUT_BITS-1:0] == '0)
            cal_thr = OUT_BITS'(1);
        else
            cal_thr = thr_wide[OUT_BITS-1:0];
        hit = bus.op_valid && (bus.op_data >= thr_q);
    end

`ifdef ADO_MANUAL_THR_EN
    logic [OUT_BITS-1:0] manual_thr;
    always_comb begin
        manual_thr = (bus.thr_wdata == '0) ? OUT_BITS'(1) : bus.thr_wdata;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            warm_q        <= '0;
            cal_cnt_q     <= '0;
            acc_q         <= '0;
            refract_q     <= '0;
            thr_q         <= '1;
            spike_count_q <= '0;
            spike_q       <= 1'b0;
            cal_done_q    <= 1'b0;
        end else begin
            spike_q    <= 1'b0;
            cal_done_q <= 1'b0;
            if (bus.abort) begin
                state_q   <= S_IDLE;
                warm_q    <= '0;
                cal_cnt_q <= '0;
                acc_q     <= '0;
                refract_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
`ifdef ADO_MANUAL_THR_EN
                        if (bus.thr_wr) begin
                            thr_q   <= manual_thr;
                            state_q <= S_ARMED;
                        end else
`endif
                        if (bus.start) begin
                            warm_q  <= '0;
                            state_q <= S_WARMUP;
                        end
                    end
                    S_WARMUP: begin
                        if (bus.op_valid) begin
                            warm_q <= warm_q + 8'(1);
                            if (warm_q == 8'(WARMUP_SAMPLES - 1)) begin
                                acc_q     <= '0;
                                cal_cnt_q <= '0;
                                state_q   <= S_CALIB;
                            end
                        end
                    end
                    S_CALIB: begin
                        if (bus.op_valid) begin
                            acc_q     <= acc_next;
                            cal_cnt_q <= cal_cnt_q + CAL_LOG2'(1);
                            if (&cal_cnt_q) begin
                                thr_q      <= cal_thr;
                                cal_done_q <= 1'b1;
                                state_q    <= S_ARMED;
                            end
                        end
                    end
                    S_ARMED: begin
                        if (hit) begin
                            spike_q   <= 1'b1;
                            refract_q <= 16'(REFRACT_SAMPLES);
                            state_q   <= S_REFRACT;
                            if (spike_count_q != 16'hFFFF)
                                spike_count_q <= spike_count_q + 16'(1);
                        end
`ifdef ADO_MANUAL_THR_EN
                        if (bus.thr_wr)
                            thr_q <= manual_thr;
`endif
                    end
                    S_REFRACT: begin
                        // Samples in hold-off only count down; the one reaching zero is still ignored.
                        if (bus.op_valid) begin
                            refract_q <= refract_q - 16'(1);
                            if (refract_q == 16'(1))
                                state_q <= S_ARMED;
                        end
`ifdef ADO_MANUAL_THR_EN
                        if (bus.thr_wr)
                            thr_q <= manual_thr;
`endif
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        warm_q    <= '0;
                        cal_cnt_q <= '0;
                        acc_q     <= '0;
                        refract_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.spike       = spike_q;
    assign bus.spike_count = spike_count_q;
    assign bus.threshold   = thr_q;
    assign bus.cal_done    = cal_done_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_ado_event_controller.sv
// Bench for ado_event_controller: vector table, directed corner sequences and a random run
// checked against a sample-level reference model. Manual-threshold checks build with ADO_MANUAL_THR_EN.
module tb_ado_event_controller;
    localparam int WARM = 2;
    localparam int CALN = 4;
    localparam int GAIN = 2;
    localparam int REFR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ado_event_controller_if #(.OUT_BITS(16)) bus ();

    ado_event_controller #(
        .OUT_BITS(16), .WARMUP_SAMPLES(2), .CAL_LOG2(2), .GAIN_SH(1), .REFRACT_SAMPLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: phase numbers are the published state codes
    int   m_phase, m_warm, m_ignore, m_thr, m_cnt;
    bit   m_spike, m_cal_done;
    int   cal_q[$];
    bit   m_tw = 1'b0;
    int   m_twd = 0;
    logic [36:0] exp_q[$];

    task automatic model_reset();
        m_phase = 0; m_warm = 0; m_ignore = 0; m_thr = 65535; m_cnt = 0;
        m_spike = 1'b0; m_cal_done = 1'b0;
        cal_q.delete();
        exp_q.delete();
    endtask

    task automatic model_step(input bit v, input int d, input bit s, input bit a,
                              input bit tw, input int twd);
        longint sum;
        int     t;
        m_spike = 1'b0;
        m_cal_done = 1'b0;
        if (a) begin
            m_phase = 0; m_warm = 0; m_ignore = 0;
            cal_q.delete();
        end else begin
            case (m_phase)
                0: if (tw) begin
                       m_thr = (twd == 0) ? 1 : twd;
                       m_phase = 3;
                   end else if (s) begin
                       m_warm = 0;
                       m_phase = 1;
                   end
                1: if (v) begin
                       m_warm++;
                       if (m_warm == WARM) begin
                           cal_q.delete();
                           m_phase = 2;
                       end
                   end
                2: if (v) begin
                       cal_q.push_back(d);
                       if (cal_q.size() == CALN) begin
                           sum = 0;
                           foreach (cal_q[k]) sum += cal_q[k];
                           t = int'(sum / CALN) * GAIN;
                           if (t > 65535) t = 65535;
                           if (t == 0) t = 1;
                           m_thr = t;
                           m_cal_done = 1'b1;
                           m_phase = 3;
                       end
                   end
                3: begin
                       if (v && d >= m_thr) begin
                           m_spike = 1'b1;
                           if (m_cnt < 65535) m_cnt++;
                           m_ignore = REFR;
                           m_phase = 4;
                       end
                       if (tw) m_thr = (twd == 0) ? 1 : twd;
                   end
                default: begin
                       if (v) begin
                           m_ignore--;
                           if (m_ignore == 0) m_phase = 3;
                       end
                       if (tw) m_thr = (twd == 0) ? 1 : twd;
                   end
            endcase
        end
    endtask

    function automatic logic [36:0] dut_pack();
        return {bus.spike, bus.cal_done, bus.state, bus.threshold, bus.spike_count};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver: apply one cycle of inputs, advance the model, sample 1 ns after the edge
    task automatic drive(input bit v, input int d, input bit s, input bit a);
        bus.op_valid = v;
        bus.op_data  = 16'(d);
        bus.start    = s;
        bus.abort    = a;
`ifdef ADO_MANUAL_THR_EN
        bus.thr_wr    = m_tw;
        bus.thr_wdata = 16'(m_twd);
`endif
        model_step(v, d, s, a, m_tw, m_twd);
        exp_q.push_back({m_spike, m_cal_done, 3'(m_phase), 16'(m_thr), 16'(m_cnt)});
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        logic [36:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=empty expected=queued", name);
        end else begin
            e = exp_q.pop_front();
            chk(name, 64'(dut_pack()), 64'(e));
        end
    endtask

    task automatic step(input string name, input bit v, input int d, input bit s, input bit a);
        drive(v, d, s, a);
        check_model(name);
    endtask

    task automatic do_reset();
        bus.op_valid = 1'b0; bus.op_data = '0; bus.start = 1'b0; bus.abort = 1'b0;
`ifdef ADO_MANUAL_THR_EN
        bus.thr_wr = 1'b0; bus.thr_wdata = '0;
`endif
        rst = 1'b1;
        #2;
        chk("rst_state", 64'(bus.state), 64'd0);
        chk("rst_thr", 64'(bus.threshold), 64'hFFFF);
        chk("rst_count", 64'(bus.spike_count), 64'd0);
        chk("rst_spike", 64'({bus.spike, bus.cal_done}), 64'd0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cal_run(input int s0, input int s1, input int s2, input int s3);
        step("cal_start", 1'b0, 0, 1'b1, 1'b0);
        step("cal_warm0", 1'b1, 9, 1'b0, 1'b0);
        step("cal_warm1", 1'b1, 9, 1'b0, 1'b0);
        step("cal_s0", 1'b1, s0, 1'b0, 1'b0);
        step("cal_s1", 1'b1, s1, 1'b0, 1'b0);
        step("cal_s2", 1'b1, s2, 1'b0, 1'b0);
        step("cal_s3", 1'b1, s3, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        s;
        logic        a;
        logic [36:0] exp;
    } vec_t;

    vec_t tbl[18];

    task automatic set_vec(input int i, input logic v, input int d, input logic s, input logic a,
                           input logic sp, input logic cd, input int st, input int thr, input int cnt);
        tbl[i].v = v; tbl[i].d = 16'(d); tbl[i].s = s; tbl[i].a = a;
        tbl[i].exp = {sp, cd, 3'(st), 16'(thr), 16'(cnt)};
    endtask

    initial begin
        // expected outputs after the edge that consumes each row
        set_vec(0,  0, 0,  1, 0, 0, 0, 1, 16'hFFFF, 0);
        set_vec(1,  1, 9,  0, 0, 0, 0, 1, 16'hFFFF, 0);
        set_vec(2,  1, 9,  0, 0, 0, 0, 2, 16'hFFFF, 0);
        set_vec(3,  1, 10, 0, 0, 0, 0, 2, 16'hFFFF, 0);
        set_vec(4,  0, 99, 0, 0, 0, 0, 2, 16'hFFFF, 0);
        set_vec(5,  1, 20, 0, 0, 0, 0, 2, 16'hFFFF, 0);
        set_vec(6,  1, 30, 0, 0, 0, 0, 2, 16'hFFFF, 0);
        set_vec(7,  1, 40, 0, 0, 0, 1, 3, 50, 0);
        set_vec(8,  0, 0,  0, 0, 0, 0, 3, 50, 0);
        set_vec(9,  1, 49, 0, 0, 0, 0, 3, 50, 0);
        set_vec(10, 1, 50, 0, 0, 1, 0, 4, 50, 1);
        set_vec(11, 1, 60, 0, 0, 0, 0, 4, 50, 1);
        set_vec(12, 1, 70, 0, 0, 0, 0, 4, 50, 1);
        set_vec(13, 1, 80, 0, 0, 0, 0, 3, 50, 1);
        set_vec(14, 1, 55, 0, 0, 1, 0, 4, 50, 2);
        set_vec(15, 0, 0,  0, 0, 0, 0, 4, 50, 2);
        set_vec(16, 0, 0,  1, 0, 0, 0, 4, 50, 2);
        set_vec(17, 0, 0,  0, 1, 0, 0, 0, 50, 2);

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        step("idle_ffe", 1'b1, 16'hFFFE, 1'b0, 1'b0);
        chk("idle_no_spike", 64'(bus.spike), 64'd0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, int'(tbl[i].d), tbl[i].s, tbl[i].a);
            chk($sformatf("vec%0d", i), 64'(dut_pack()), 64'(tbl[i].exp));
            check_model($sformatf("vec%0d_model", i));
        end

        // saturation high and zero floor
        cal_run(16'hC000, 16'hC000, 16'hC000, 16'hC000);
        chk("sat_thr", 64'(bus.threshold), 64'hFFFF);
        chk("sat_cal_done", 64'(bus.cal_done), 64'd1);
        step("sat_after", 1'b0, 0, 1'b0, 1'b0);
        chk("sat_cal_done_low", 64'(bus.cal_done), 64'd0);
        step("sat_abort", 1'b0, 0, 1'b0, 1'b1);
        cal_run(0, 0, 0, 0);
        chk("zero_thr", 64'(bus.threshold), 64'd1);
        chk("zero_state", 64'(bus.state), 64'd3);
        step("zero_abort", 1'b0, 0, 1'b0, 1'b1);

        // abort mid-calibration alongside start, then a clean recalibration
        step("ab_start", 1'b0, 0, 1'b1, 1'b0);
        step("ab_w0", 1'b1, 9, 1'b0, 1'b0);
        step("ab_w1", 1'b1, 9, 1'b0, 1'b0);
        step("ab_c0", 1'b1, 100, 1'b0, 1'b0);
        step("ab_c1", 1'b1, 100, 1'b0, 1'b0);
        step("ab_abort", 1'b0, 0, 1'b1, 1'b1);
        chk("ab_state", 64'(bus.state), 64'd0);
        chk("ab_thr_kept", 64'(bus.threshold), 64'd1);
        cal_run(4, 4, 4, 4);
        chk("ab_recal_thr", 64'(bus.threshold), 64'd8);
        chk("ab_count_kept", 64'(bus.spike_count), 64'd2);
        step("ab_end", 1'b0, 0, 1'b0, 1'b1);

`ifdef ADO_MANUAL_THR_EN
        m_tw = 1'b1; m_twd = 100;
        step("man_wr", 1'b0, 0, 1'b1, 1'b0);
        m_tw = 1'b0;
        chk("man_state", 64'(bus.state), 64'd3);
        chk("man_thr", 64'(bus.threshold), 64'd100);
        step("man_hit", 1'b1, 100, 1'b0, 1'b0);
        chk("man_spike", 64'(bus.spike), 64'd1);
        step("man_abort", 1'b0, 0, 1'b0, 1'b1);
        step("man_start", 1'b0, 0, 1'b1, 1'b0);
        step("man_w0", 1'b1, 9, 1'b0, 1'b0);
        step("man_w1", 1'b1, 9, 1'b0, 1'b0);
        m_tw = 1'b1; m_twd = 77;
        step("man_calwr", 1'b1, 5, 1'b0, 1'b0);
        m_tw = 1'b0;
        chk("man_cal_ignored", 64'(bus.threshold), 64'd100);
        chk("man_cal_state", 64'(bus.state), 64'd2);
        step("man_end", 1'b0, 0, 1'b0, 1'b1);
`endif

        // random run against the model, with one asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit v, s, a;
            int d;
            if (i == 2000) do_reset();
            v = ($urandom_range(0, 99) < 70);
            d = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 65535))
                                              : int'($urandom_range(0, 255));
            s = ($urandom_range(0, 99) < 6);
            a = ($urandom_range(0, 99) < 2);
`ifdef ADO_MANUAL_THR_EN
            m_tw  = ($urandom_range(0, 99) < 2);
            m_twd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 200));
`endif
            step("rand", v, d, s, a);
        end
        m_tw = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
